// File: rtl/lcd_pkg.sv
// Shared mode encodings, colour-bar table and width helper for the LCD timing generator.
// Pure declarations: no logic, no latency, no flow control.
package lcd_pkg;

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        GRID  = 2'd1,
        GRAD  = 2'd2,
        SOLID = 2'd3
    } lcd_mode_e;

    // Returns {R,G,B} on/off for bar 0 (leftmost) .. bar 7 (rightmost).
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111; // white
            3'd1:    rgb = 3'b110; // yellow
            3'd2:    rgb = 3'b011; // cyan
            3'd3:    rgb = 3'b010; // green
            3'd4:    rgb = 3'b101; // magenta
            3'd5:    rgb = 3'b100; // red
            3'd6:    rgb = 3'b001; // blue
            default: rgb = 3'b000; // black
        endcase
        return rgb;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational test-pattern source: maps (x', y, mode, solid colour) to RGB.
// Zero latency, no flow control; the parent registers the result with de/sync.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5
) (
    input  logic [XW-1:0]          x,
    input  logic [YW-1:0]          y,
    input  logic [1:0]             mode,
    input  logic [R_W+G_W+B_W-1:0] solid_rgb,
    output logic [R_W-1:0]         r,
    output logic [G_W-1:0]         g,
    output logic [B_W-1:0]         b
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;
    logic [2:0] bar_on;
    logic       grid_on;

    // Bar index by threshold compare; anything past bar 6 lands in bar 7, which absorbs the remainder.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (32'(x) >= 32'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    assign bar_on  = bar_rgb(bar_idx);
    assign grid_on = (5'(x) == 5'd0) || (5'(y) == 5'd0);

    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        case (lcd_mode_e'(mode))
            BARS: begin
                r = {R_W{bar_on[2]}};
                g = {G_W{bar_on[1]}};
                b = {B_W{bar_on[0]}};
            end
            GRID: begin
                r = {R_W{grid_on}};
                g = {G_W{grid_on}};
                b = {B_W{grid_on}};
            end
            GRAD: begin
                r = R_W'(32'(x) >> 3);
                g = G_W'(32'(y) >> 3);
                b = B_W'((32'(x) + 32'(y)) >> 3);
            end
            SOLID: begin
                r = solid_rgb[R_W+G_W+B_W-1 -: R_W];
                g = solid_rgb[G_W+B_W-1 -: G_W];
                b = solid_rgb[B_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB LCD raster timing generator with test patterns; all pins registered, 1 clk from counters, no backpressure (en=0 parks the raster).
// Optional LCD_TP_SCROLL_EN: pattern x is offset by a per-frame counter so patterns scroll left 1 px/frame.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [1:0]                      mode,
    input  logic [R_W+G_W+B_W-1:0]          solid_rgb,
    output logic                            lcd_de,
    output logic                            lcd_hsync,
    output logic                            lcd_vsync,
    output logic [R_W-1:0]                  lcd_r,
    output logic [G_W-1:0]                  lcd_g,
    output logic [B_W-1:0]                  lcd_b,
    output logic [clog2w(H_ACTIVE)-1:0]     pix_x,
    output logic [clog2w(V_ACTIVE)-1:0]     pix_y,
    output logic                            frame_start,
    output logic [15:0]                     frame_cnt
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   XW      = clog2w(H_ACTIVE);
    localparam int   YW      = clog2w(V_ACTIVE);
    localparam int   HW      = clog2w(H_TOTAL);
    localparam int   VW      = clog2w(V_TOTAL);
    localparam int   RGB_W   = R_W + G_W + B_W;
    localparam logic HS_ACT  = 1'(HS_POL);
    localparam logic VS_ACT  = 1'(VS_POL);

    if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("lcd_timing_gen: timing parameters must be >= 1 and H_ACTIVE >= 8");
    end

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             h_last, v_last, frame_first, frame_wrap;
    logic             h_act, v_act, de_c, hs_c, vs_c;
    logic [1:0]       mode_q, mode_eff;
    logic [RGB_W-1:0] solid_q, solid_eff;
    logic [XW-1:0]    x_raw, x_pat;
    logic [YW-1:0]    y_raw;
    logic [R_W-1:0]   pat_r;
    logic [G_W-1:0]   pat_g;
    logic [B_W-1:0]   pat_b;

    assign h_last      = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last      = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);
    assign frame_wrap  = h_last && v_last;
    assign h_act       = (h_cnt < HW'(H_ACTIVE));
    assign v_act       = (v_cnt < VW'(V_ACTIVE));
    assign hs_c        = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_c        = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign de_c        = h_act && v_act;
    assign x_raw       = h_act ? h_cnt[XW-1:0] : '0;
    assign y_raw       = v_act ? v_cnt[YW-1:0] : '0;

    // Pixel (0,0) is generated in the same cycle mode/colour are latched, so bypass the latch there.
    assign mode_eff  = frame_first ? mode      : mode_q;
    assign solid_eff = frame_first ? solid_rgb : solid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= BARS;
            solid_q   <= '0;
            frame_cnt <= '0;
        end else if (en) begin
            if (frame_first) begin
                mode_q  <= mode;
                solid_q <= solid_rgb;
            end
            if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef LCD_TP_SCROLL_EN
    logic [XW-1:0] offset;
    logic [XW:0]   x_sum;

    assign x_sum = {1'b0, x_raw} + {1'b0, offset};
    assign x_pat = (x_sum >= (XW+1)'(H_ACTIVE)) ? XW'(x_sum - (XW+1)'(H_ACTIVE)) : x_sum[XW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset <= '0;
        end else if (!en) begin
            offset <= '0;
        end else if (frame_wrap) begin
            offset <= (offset == XW'(H_ACTIVE - 1)) ? '0 : offset + 1'b1;
        end
    end
`else
    assign x_pat = x_raw;
`endif

    lcd_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW),
        .R_W      (R_W),
        .G_W      (G_W),
        .B_W      (B_W)
    ) u_pattern (
        .x         (x_pat),
        .y         (y_raw),
        .mode      (mode_eff),
        .solid_rgb (solid_eff),
        .r         (pat_r),
        .g         (pat_g),
        .b         (pat_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcd_de                 <= 1'b0;
            lcd_hsync              <= ~HS_ACT;
            lcd_vsync              <= ~VS_ACT;
            {lcd_r, lcd_g, lcd_b}  <= '0;
            pix_x                  <= '0;
            pix_y                  <= '0;
            frame_start            <= 1'b0;
        end else if (!en) begin
            lcd_de                 <= 1'b0;
            lcd_hsync              <= ~HS_ACT;
            lcd_vsync              <= ~VS_ACT;
            {lcd_r, lcd_g, lcd_b}  <= '0;
            pix_x                  <= '0;
            pix_y                  <= '0;
            frame_start            <= 1'b0;
        end else begin
            lcd_de                 <= de_c;
            lcd_hsync              <= hs_c ? HS_ACT : ~HS_ACT;
            lcd_vsync              <= vs_c ? VS_ACT : ~VS_ACT;
            {lcd_r, lcd_g, lcd_b}  <= de_c ? {pat_r, pat_g, pat_b} : '0;
            pix_x                  <= x_raw;
            pix_y                  <= y_raw;
            frame_start            <= frame_first;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen with a 16/2/2/2 x 4/1/1/1 raster (22 clk/line, 154 clk/frame).
// Outputs are sampled on the falling edge; k counts falling edges since the raster (re)started.
module tb_lcd_timing_gen;

    localparam int LINE  = 22;
    localparam int FRAME = 154;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] solid_rgb;
    logic        lcd_de, lcd_hsync, lcd_vsync, frame_start;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic [3:0]  pix_x;
    logic [1:0]  pix_y;
    logic [15:0] frame_cnt;
    logic [15:0] rgb;

    int n_run  = 0;
    int n_fail = 0;
    int k      = 0;

    assign rgb = {lcd_r, lcd_g, lcd_b};

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (0),  .VS_POL (0),
        .R_W      (5),  .G_W (6),  .B_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .lcd_de      (lcd_de),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_r       (lcd_r),
        .lcd_g       (lcd_g),
        .lcd_b       (lcd_b),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    function automatic int pk(input int f, input int x, input int y);
        return f * FRAME + y * LINE + x + 1;
    endfunction

    function automatic int offs(input int f);
`ifdef LCD_TP_SCROLL_EN
        return f % 16;
`else
        return (f < 0) ? 1 : 0;
`endif
    endfunction

    function automatic logic [15:0] grid_exp(input int f, input int x, input int y);
        int xs;
        xs = (x + offs(f)) % 16;
        return ((xs % 32 == 0) || (y % 32 == 0)) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic logic [15:0] grad_exp(input int f, input int x, input int y);
        int xs;
        xs = (x + offs(f)) % 16;
        return {5'(xs >> 3), 6'(y >> 3), 5'((xs + y) >> 3)};
    endfunction

    initial begin
        int de_n, hs_n, vs_n, fs_n, hs_first, bad;
        rst = 1'b0; en = 1'b1; mode = 2'd0; solid_rgb = 16'h0000;
        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; hs_first = 0; bad = 0;

        repeat (3) @(negedge clk);
        check("rst_de",     32'(lcd_de),      32'd0);
        check("rst_hsync",  32'(lcd_hsync),   32'd1);
        check("rst_vsync",  32'(lcd_vsync),   32'd1);
        check("rst_rgb",    32'(rgb),         32'd0);
        check("rst_fs",     32'(frame_start), 32'd0);
        check("rst_fcnt",   32'(frame_cnt),   32'd0);
        check("rst_pix",    32'({pix_x, pix_y}), 32'd0);

        // Frame 0: timing shape and colour bars; switch to solid red mid-frame.
        rst = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            de_n += int'(lcd_de);
            fs_n += int'(frame_start);
            if (!lcd_hsync) hs_n++;
            if (!lcd_vsync) vs_n++;
            if (!lcd_hsync && hs_first == 0) hs_first = k;
            case (k)
                1: begin
                    check("first_fs",    32'(frame_start), 32'd1);
                    check("first_de",    32'(lcd_de),      32'd1);
                    check("bar_x0",      32'(rgb),         32'hFFFF);
                    check("first_pix",   32'({pix_x, pix_y}), 32'd0);
                end
                2:  begin check("bar_x1", 32'(rgb), 32'hFFFF); check("pix_x1", 32'(pix_x), 32'd1); end
                3:  check("bar_x2_yellow", 32'(rgb), 32'hFFE0);
                15: check("bar_x14_black", 32'({lcd_de, rgb}), 32'h10000);
                16: begin check("bar_x15_black", 32'({lcd_de, rgb}), 32'h10000); check("pix_x15", 32'(pix_x), 32'd15); end
                50: begin mode = 2'd3; solid_rgb = 16'hF800; end
                69: begin check("midframe_still_bars", 32'(rgb), 32'hFFE0); check("pix_y3", 32'(pix_y), 32'd3); end
                153: check("fcnt_before_wrap", 32'(frame_cnt), 32'd0);
                154: check("fcnt_after_wrap",  32'(frame_cnt), 32'd1);
                default: ;
            endcase
        end
        check("f0_de_count",    32'(de_n),     32'd64);
        check("f0_hsync_count", 32'(hs_n),     32'd14);
        check("f0_vsync_count", 32'(vs_n),     32'd22);
        check("f0_fs_count",    32'(fs_n),     32'd1);
        check("hsync_first_k",  32'(hs_first), 32'd19);

        // Frame 1: solid colour picked up at frame start.
        de_n = 0; fs_n = 0; bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            de_n += int'(lcd_de);
            fs_n += int'(frame_start);
            if (lcd_de && rgb != 16'hF800) bad++;
            if (k == FRAME + 1) check("fs_period", 32'(frame_start), 32'd1);
        end
        check("f1_de_count",  32'(de_n), 32'd64);
        check("f1_solid_bad", 32'(bad),  32'd0);
        check("f1_fs_count",  32'(fs_n), 32'd1);
        check("f1_fcnt",      32'(frame_cnt), 32'd2);

        // en dropped mid-line for 10 clk.
        run_to(320);
        check("pre_drop_de", 32'(lcd_de), 32'd1);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (lcd_de || !lcd_hsync || !lcd_vsync || rgb != 16'h0 || frame_start) bad++;
        end
        check("en_low_idle", 32'(bad), 32'd0);
        en = 1'b1;
        k = 0;
        tick();
        check("reen_fs",   32'(frame_start), 32'd1);
        check("reen_de",   32'(lcd_de),      32'd1);
        check("reen_rgb",  32'(rgb),         32'hF800);
        check("reen_fcnt", 32'(frame_cnt),   32'd2);

        // frame_cnt wrap from a preloaded value.
        run_to(10);
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        run_to(12);
        check("fcnt_preload", 32'(frame_cnt), 32'hFFFF);
        run_to(153);
        check("fcnt_hold",    32'(frame_cnt), 32'hFFFF);
        run_to(154);
        check("fcnt_wrap0",   32'(frame_cnt), 32'd0);
        run_to(160);
        mode = 2'd1;
        run_to(308);
        check("fcnt_wrap1",   32'(frame_cnt), 32'd1);

        // Frame 2: grid.
        run_to(pk(2, 5, 0));  check("grid_5_0",  32'(rgb), 32'(grid_exp(2, 5, 0)));
        run_to(pk(2, 0, 1));  check("grid_0_1",  32'(rgb), 32'(grid_exp(2, 0, 1)));
        run_to(pk(2, 5, 1));  check("grid_5_1",  32'(rgb), 32'(grid_exp(2, 5, 1)));
        run_to(pk(2, 13, 2)); check("grid_13_2", 32'(rgb), 32'(grid_exp(2, 13, 2)));
        run_to(400);
        mode = 2'd2;

        // Frames 3..20: gradient, across a full scroll-offset wrap when scrolling is built in.
        for (int f = 3; f <= 20; f++) begin
            run_to(pk(f, 0, 0));  check("grad_0_0",  32'(rgb), 32'(grad_exp(f, 0, 0)));
            run_to(pk(f, 1, 0));  check("grad_1_0",  32'(rgb), 32'(grad_exp(f, 1, 0)));
            run_to(pk(f, 9, 2));  check("grad_9_2",  32'(rgb), 32'(grad_exp(f, 9, 2)));
            run_to(pk(f, 15, 3)); check("grad_15_3", 32'(rgb), 32'(grad_exp(f, 15, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Parametrised RGB LCD raster timing generator with a built-in test-pattern source. It is the next generation of the fixed 800x480 timing/pattern module used by the nanolcd top level. Horizontal and vertical timing, sync polarity and colour depth are parameters, and pattern mode is selectable at run time. It drives the LCD_DE/HSYNC/VSYNC/R/G/B pins directly and exports pixel coordinates and frame status for downstream logic.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 48, hsync width (clocks)
H_BP, 40, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 13, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 29, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
R_W, 5, red width
G_W, 6, green width
B_W, 5, blue width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
en  in  1  run enable
mode  in  2  pattern select: 0 colour bars, 1 grid, 2 gradient, 3 solid
solid_rgb  in  R_W+G_W+B_W  solid colour {R,G,B} used in mode 3
lcd_de  out  1  data enable
lcd_hsync  out  1  horizontal sync
lcd_vsync  out  1  vertical sync
lcd_r  out  R_W  red
lcd_g  out  G_W  green
lcd_b  out  B_W  blue
pix_x  out  clog2(H_ACTIVE)  x of current output pixel (valid when lcd_de)
pix_y  out  clog2(V_ACTIVE)  y of current output pixel (valid when lcd_de)
frame_start  out  1  one-cycle pulse, coincident with first lcd_de of each frame
frame_cnt  out  16  frames completed, wraps at 65535->0

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-low.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on the h wrap and runs 0..V_TOTAL-1.
- Horizontal regions: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical regions are the same, in lines.
- Sync asserts (level = HS_POL/VS_POL) inside its sync region. lcd_de = h active AND v active.
- All outputs are registered. Latency is 1 clk from counter value to pins, and all outputs stay mutually aligned.
- Reset: counters 0, lcd_de=0, syncs at inactive level, RGB=0, pix_x/pix_y=0, frame_start=0, frame_cnt=0.
- en=0: counters held at 0; syncs inactive, lcd_de=0, RGB=0. Deassert then reassert restarts at h=0,v=0, so the first output frame is complete.
- mode is sampled once per frame, at h_cnt=0 and v_cnt=0, into mode_q. A mid-frame change takes effect from the next frame only. solid_rgb is sampled at the same point.
- frame_cnt increments when the (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) state is passed. frame_start is high for the pixel (0,0).
- Patterns, with RGB forced to 0 when lcd_de=0:
  - Bars: 8 vertical bars, each H_ACTIVE/8 wide (integer division; the remainder goes to the last bar). Order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale channels are all-ones.
  - Grid: white where x[4:0]==0 or y[4:0]==0, else black.
  - Gradient: R=x[R_W+2:3], G=y[G_W+2:3], B=(x+y)[B_W+2:3], modulo wrap.
  - Solid: solid_rgb as latched.
- Elaboration check: all timing parameters >=1 and H_ACTIVE >= 8; otherwise $error.

Optional Feature:
LCD_TP_SCROLL_EN.
- Defined: an offset register (width of pix_x) increments by 1 at every frame wrap and wraps at H_ACTIVE-1 -> 0. Bars, grid and gradient use x' = (x+offset) mod H_ACTIVE, so patterns scroll left 1 px/frame. The offset resets to 0 and is held at 0 while en=0.
- Undefined: no offset logic; x' = x.

Decomposition:
- Package lcd_pkg:
  - mode encodings (BARS=0, GRID=1, GRAD=2, SOLID=3)
  - bar colour table (8 entries, 3-bit on/off per channel)
  - clog2-based width helper
- Sub-module lcd_pattern_gen: combinational map of (x', y, mode_q, solid colour) to RGB. The parent registers its output alongside de/sync.

Test Plan:
Use sim parameters H 16/2/2/2 (H_TOTAL 22) and V 4/1/1/1 (V_TOTAL 7), i.e. 154 clk/frame, with HS_POL=VS_POL=0.
1. Release reset with en=1 -> first lcd_de 1 clk after release, 16 high per line, 4 lines; hsync low 2 clk starting 19 clk after line start; frame_start period exactly 154 clk.
2. Mode 0 -> pix_x 0,1 white (all-ones); pix_x 14,15 black; pix_x 2 yellow (R,G full, B=0).
3. Mode changed 0->3 mid-frame with solid_rgb=16'hF800 -> current frame stays bars; next frame all active pixels R=31,G=0,B=0.
4. en dropped mid-line for 10 clk, then raised -> syncs inactive and de=0 while low; next frame_start exactly 1 clk after re-enable.
5. Run 65537 frames (frame_cnt forced/preloaded near wrap) -> frame_cnt reads 0 then 1.
6. With LCD_TP_SCROLL_EN, mode 2 -> pixel (0,0) R value equals frame n's pixel (1,0) value in frame n+1; offset wraps after 16 frames.
